// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load path: size encodings (common with the store
// mux), FSM state encodings and the default read timeout.
package load_align_unit_pkg;

  localparam int LD_ADDR_W      = 32;
  localparam int LD_DATA_W      = 32;
  localparam int LD_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_X = 2'd3
  } ld_size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RESP = 3'd3,
    ST_ERR  = 3'd4
  } ld_state_e;

  // Illegal size or an address not naturally aligned to the access size.
  function automatic logic ld_addr_bad(input logic [1:0] lane, input logic [1:0] size);
    return (size == LD_X) ||
           ((size == LD_H) && lane[0]) ||
           ((size == LD_W) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Core-side load request/response and data-memory read port of the load unit.
interface load_align_unit_if
  import load_align_unit_pkg::*;
#(
  parameter int ADDR_W = LD_ADDR_W,
  parameter int DATA_W = LD_DATA_W
);
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [1:0]        ld_size;
  logic              ld_unsigned;
  logic              ld_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_err;
  logic              busy;

  modport slave (
    input  ld_req, ld_addr, ld_size, ld_unsigned, mem_gnt, mem_rvalid, mem_rdata,
    output ld_ready, mem_req, mem_addr, ld_valid, ld_data, ld_err, busy
  );

  modport master (
    output ld_req, ld_addr, ld_size, ld_unsigned, mem_gnt, mem_rvalid, mem_rdata,
    input  ld_ready, mem_req, mem_addr, ld_valid, ld_data, ld_err, busy
  );
endinterface

// File: rtl/load_align_unit_extend.sv
// Lane select and sign/zero extension of a returned 32-bit memory word.
module load_extend
  import load_align_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane and extend it; word (and illegal) passes through.
  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o  = rdata_i;
    case (size_i)
      LD_B:    data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      LD_H:    data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load unit: issues word-aligned reads, extracts and extends the addressed
// lane, and reports misalignment or read timeout on the result handshake.
//
// state | meaning
// IDLE  | ready for a new load (once the previous result pulse has gone)
// REQ   | mem_req high, waiting for mem_gnt
// WAIT  | granted, counting cycles until mem_rvalid or timeout
// RESP  | good result on ld_valid/ld_data
// ERR   | error result follows on ld_valid/ld_err next cycle
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int ADDR_W  = LD_ADDR_W,
  parameter int DATA_W  = LD_DATA_W,
  parameter int TIMEOUT = LD_TIMEOUT_DEF
)(
  input logic         clk,
  input logic         rst_n,
  load_align_unit_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              ld_valid_q;
  logic              ld_err_q;
  logic [DATA_W-1:0] ld_data_q;
  logic [31:0]       ext_data;
  logic              ready;
  logic              accept;
  logic              rd_done;

  // The result pulse of an error lands while already back in IDLE, so
  // readiness also waits for that pulse to clear.
  assign ready   = (state_q == ST_IDLE) && !ld_valid_q;
  assign accept  = ready && bus.ld_req;
  assign rd_done = (state_q == ST_WAIT) && bus.mem_rvalid;

  load_extend u_extend (
    .rdata_i    (bus.mem_rdata),
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  // Next-state and timeout counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ld_addr_bad(bus.ld_addr[1:0], bus.ld_size) ? ST_ERR : ST_REQ;
      ST_REQ: begin
        if (bus.mem_gnt) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid)                 state_d = ST_RESP;
        else if (cnt_q == CNT_W'(TIMEOUT))  state_d = ST_ERR;
        else                                cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RESP, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture; mem_addr stays stable for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      mem_addr_q <= '0;
    end else if (accept) begin
      lane_q     <= bus.ld_addr[1:0];
      size_q     <= bus.ld_size;
      uns_q      <= bus.ld_unsigned;
      mem_addr_q <= {bus.ld_addr[ADDR_W-1:2], 2'b00};
    end
  end

  // Result registers: one-cycle pulse, data forced to zero except on success.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_valid_q <= 1'b0;
      ld_err_q   <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      ld_valid_q <= rd_done || (state_q == ST_ERR);
      ld_err_q   <= (state_q == ST_ERR);
      ld_data_q  <= rd_done ? ext_data : '0;
    end
  end

  assign bus.ld_ready = ready;
  assign bus.busy     = ~ready;
  assign bus.mem_req  = (state_q == ST_REQ);
  assign bus.mem_addr = mem_addr_q;
  assign bus.ld_valid = ld_valid_q;
  assign bus.ld_err   = ld_err_q;
  assign bus.ld_data  = ld_data_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: directed table, randomized loads against a
// behavioural model, and a reset-during-access sequence.
module tb_load_align_unit;
  import load_align_unit_pkg::*;

  localparam int TMO = 15;
  localparam int WIN = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_align_unit_if bus_if ();

  load_align_unit #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    bit          noise;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
    int          exp_reqs;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: lane value computed arithmetically from the byte address.
  function automatic void model_value(input logic [31:0] addr, input logic [1:0] size,
                                      input logic uns, input logic [31:0] rdata,
                                      output logic [31:0] data, output bit err);
    longint unsigned v;
    int unsigned lane = addr % 4;
    err = (size == 3) || (size == 1 && (lane % 2) != 0) || (size == 2 && lane != 0);
    v = 0;
    if (!err) begin
      if (size == 0) begin
        v = (longint'(rdata) >> (8 * lane)) % 256;
        if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
      end else if (size == 1) begin
        v = (longint'(rdata) >> (16 * (lane / 2))) % 65536;
        if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
      end else begin
        v = longint'(rdata);
      end
    end
    data = v[31:0];
  endfunction

  // Reference timing: cycles from request to ld_valid, and mem_req cycles.
  function automatic void model_timing(input bit addr_err, input int gnt_dly, input int rv_dly,
                                       inout logic [31:0] data, inout bit err,
                                       output int lat, output int reqs);
    if (addr_err) begin
      lat = 2; reqs = 0;
    end else if (rv_dly <= TMO) begin
      lat = 3 + gnt_dly + rv_dly; reqs = gnt_dly + 1;
    end else begin
      lat = gnt_dly + 4 + TMO; reqs = gnt_dly + 1; err = 1; data = 0;
    end
  endfunction

  task automatic run_load(input vec_t v, input string tag);
    logic [31:0] got_data = 32'hX;
    bit          got_err = 0;
    int          got_lat = -1, got_reqs = 0, valids = 0, ready_cyc = -1, gnt_cyc = -1;
    bit          addr_ok = 1;
    logic        ready0;
    @(negedge clk);
    ready0 = bus_if.ld_ready;
    bus_if.ld_req      = 1'b1;
    bus_if.ld_addr     = v.addr;
    bus_if.ld_size     = v.size;
    bus_if.ld_unsigned = v.uns;
    bus_if.mem_gnt     = 1'b0;
    bus_if.mem_rvalid  = 1'b0;
    bus_if.mem_rdata   = $urandom;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      if (bus_if.ld_valid) begin
        valids++;
        if (valids == 1) begin
          got_data = bus_if.ld_data; got_err = bus_if.ld_err; got_lat = c;
        end
      end else if (bus_if.ld_ready && valids > 0 && ready_cyc < 0) begin
        ready_cyc = c;
      end
      bus_if.mem_gnt = 1'b0;
      if (bus_if.mem_req) begin
        got_reqs++;
        if (bus_if.mem_addr !== {v.addr[31:2], 2'b00}) addr_ok = 0;
        if (got_reqs - 1 == v.gnt_dly) begin
          bus_if.mem_gnt = 1'b1; gnt_cyc = c;
        end
      end
      bus_if.mem_rvalid = (gnt_cyc >= 0) && (gnt_cyc != c) && (c == gnt_cyc + 1 + v.rv_dly);
      bus_if.mem_rdata  = bus_if.mem_rvalid ? v.rdata : $urandom;
      bus_if.ld_req     = v.noise && !bus_if.ld_ready;
      bus_if.ld_addr    = $urandom;
      bus_if.ld_size    = 2'($urandom_range(0, 3));
    end
    bus_if.ld_req = 1'b0; bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
    check({tag, " ready_at_start"}, 32'(ready0), 32'd1);
    check({tag, " data"}, got_data, v.exp_data);
    check({tag, " err"}, 32'(got_err), 32'(v.exp_err));
    check({tag, " latency"}, got_lat, v.exp_lat);
    check({tag, " valid_pulses"}, valids, 1);
    check({tag, " mem_req_cycles"}, got_reqs, v.exp_reqs);
    check({tag, " mem_addr_stable"}, 32'(addr_ok), 32'd1);
    check({tag, " ready_back"}, ready_cyc, v.exp_lat + 1);
  endtask

  vec_t tbl [11];

  initial begin
    vec_t rv;
    logic [31:0] md;
    bit me;
    int wd;
    tbl[0]  = '{32'h1003, 2'd0, 1'b0, 32'h80FF1234, 0, 0,  1'b0, 32'hFFFFFF80, 1'b0, 3,  1};
    tbl[1]  = '{32'h1002, 2'd1, 1'b1, 32'h80015678, 0, 0,  1'b0, 32'h00008001, 1'b0, 3,  1};
    tbl[2]  = '{32'h1002, 2'd1, 1'b0, 32'h80015678, 1, 2,  1'b1, 32'hFFFF8001, 1'b0, 6,  2};
    tbl[3]  = '{32'h2000, 2'd2, 1'b0, 32'hDEADBEEF, 3, 1,  1'b1, 32'hDEADBEEF, 1'b0, 7,  4};
    tbl[4]  = '{32'h1001, 2'd1, 1'b0, 32'h12345678, 0, 0,  1'b1, 32'h00000000, 1'b1, 2,  0};
    tbl[5]  = '{32'h1000, 2'd3, 1'b0, 32'h12345678, 0, 0,  1'b0, 32'h00000000, 1'b1, 2,  0};
    tbl[6]  = '{32'h2002, 2'd2, 1'b1, 32'h12345678, 0, 0,  1'b0, 32'h00000000, 1'b1, 2,  0};
    tbl[7]  = '{32'h2004, 2'd2, 1'b0, 32'hCAFEF00D, 0, 20, 1'b1, 32'h00000000, 1'b1, 19, 1};
    tbl[8]  = '{32'h2008, 2'd2, 1'b1, 32'h12345678, 2, 15, 1'b0, 32'h12345678, 1'b0, 20, 3};
    tbl[9]  = '{32'h2006, 2'd0, 1'b0, 32'h007F0000, 0, 3,  1'b0, 32'h0000007F, 1'b0, 6,  1};
    tbl[10] = '{32'h2005, 2'd0, 1'b1, 32'h0000A500, 1, 0,  1'b0, 32'h000000A5, 1'b0, 4,  2};

    bus_if.ld_req = 1'b0; bus_if.ld_addr = '0; bus_if.ld_size = '0; bus_if.ld_unsigned = 1'b0;
    bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0; bus_if.mem_rdata = '0;
    #12;
    check("rst ld_ready", 32'(bus_if.ld_ready), 32'd1);
    check("rst busy", 32'(bus_if.busy), 32'd0);
    check("rst mem_req", 32'(bus_if.mem_req), 32'd0);
    check("rst mem_addr", bus_if.mem_addr, 32'd0);
    check("rst ld_valid", 32'(bus_if.ld_valid), 32'd0);
    check("rst ld_err", 32'(bus_if.ld_err), 32'd0);
    check("rst ld_data", bus_if.ld_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_load(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv.addr    = $urandom;
      rv.size    = 2'($urandom_range(0, 3));
      rv.uns     = 1'($urandom_range(0, 1));
      rv.rdata   = $urandom;
      rv.gnt_dly = $urandom_range(0, 3);
      rv.rv_dly  = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 5) : $urandom_range(0, 4);
      rv.noise   = 1'($urandom_range(0, 1));
      model_value(rv.addr, rv.size, rv.uns, rv.rdata, md, me);
      model_timing(me, rv.gnt_dly, rv.rv_dly, md, me, rv.exp_lat, rv.exp_reqs);
      rv.exp_data = md;
      rv.exp_err  = me;
      run_load(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of WAIT abandons the access immediately.
    @(negedge clk);
    bus_if.ld_req = 1'b1; bus_if.ld_addr = 32'h3000; bus_if.ld_size = 2'd2; bus_if.ld_unsigned = 1'b0;
    @(negedge clk);
    bus_if.ld_req = 1'b0;
    wd = 0;
    while (!bus_if.mem_req && wd < 10) begin
      @(negedge clk); wd++;
    end
    check("rstmid mem_req_seen", 32'(bus_if.mem_req), 32'd1);
    bus_if.mem_gnt = 1'b1;
    @(negedge clk);
    bus_if.mem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid ld_ready", 32'(bus_if.ld_ready), 32'd1);
    check("rstmid busy", 32'(bus_if.busy), 32'd0);
    check("rstmid mem_req", 32'(bus_if.mem_req), 32'd0);
    check("rstmid mem_addr", bus_if.mem_addr, 32'd0);
    check("rstmid ld_valid", 32'(bus_if.ld_valid), 32'd0);
    check("rstmid ld_err", 32'(bus_if.ld_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{32'h4001, 2'd0, 1'b0, 32'h0000FE00, 0, 1, 1'b1, 32'hFFFFFFFE, 1'b0, 4, 1};
    run_load(rv, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
